mem_arbiter: RTL and testbench

- Sequences and shares the single-port, byte-array, word-wide data memory between the instruction-fetch requester (I, read-only) and the load/store requester (D).
- Issues word-aligned accesses only. Converts byte/halfword stores into read-modify-write pairs. Extracts and extends subword loads.
- Rejects misaligned or out-of-range accesses with a fault acknowledge, without touching memory.
- Sits between the CPU core and the memory block; it is the only driver of the memory's enable/write/address/data_in.

---
 rtl/mem_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, word-wide data memory between the
// instruction fetch port (I, read-only) and the load/store port (D).
// Subword stores become read-modify-write pairs; subword loads are extracted
// and extended here. Misaligned or out-of-range accesses fault without
// touching memory.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | arbitrate; the grant cycle drives the first memory access
// RD_WAIT   | read data returned on mem_rdata; ack the owner
// WR_DONE   | store complete; ack D
// RMW_MERGE | old word on mem_rdata; write back with the lane replaced
// FAULT_ACK | ack the owner with fault=1, rdata=0
module mem_arbiter #(
  parameter int unsigned MEM_SIZE     = 64000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_fault,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic        mem_enable,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_DONE, RMW_MERGE, FAULT_ACK} state_t;

  state_t      state, state_nxt;
  logic        own_i;
  logic [3:0]  starve_cnt;
  logic        grant_i, grant_d;
  logic        i_bad, d_bad;
  logic [31:0] i_aligned, d_aligned;
  logic [4:0]  lane_shift;
  logic [31:0] shifted, load_ext, merged;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic        i_fault_q, d_fault_q;

  // The last byte of the aligned word must lie inside the memory.
  function automatic logic out_of_range(input logic [31:0] a);
    logic [32:0] last;
    last = {1'b0, a[31:2], 2'b00} + 33'd3;
    return last > 33'(MEM_SIZE - 1);
  endfunction

  assign i_aligned = {i_addr[31:2], 2'b00};
  assign d_aligned = {d_addr[31:2], 2'b00};
  assign i_bad     = (i_addr[1:0] != 2'b00) || out_of_range(i_addr);
  assign d_bad     = (d_size == 2'd3) ||
                     (d_size == 2'd1 && d_addr[0]) ||
                     (d_size == 2'd2 && d_addr[1:0] != 2'b00) ||
                     out_of_range(d_addr);

  // Byte lane of a subword access, as a bit shift (little-endian)
  assign lane_shift = (d_size == 2'd0) ? {d_addr[1:0], 3'b000} : {d_addr[1], 4'b0000};
  assign shifted    = mem_rdata >> lane_shift;

  // Subword load extraction and sign/zero extension
  always_comb begin
    case (d_size)
      2'd0:    load_ext = {{24{d_signed & shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = {{16{d_signed & shifted[15]}}, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Replace the addressed lane of the old word with the store data
  always_comb begin
    if (d_size == 2'd0)
      merged = (mem_rdata & ~(32'h0000_00FF << lane_shift)) |
               ({24'd0, d_wdata[7:0]} << lane_shift);
    else
      merged = (mem_rdata & ~(32'h0000_FFFF << lane_shift)) |
               ({16'd0, d_wdata[15:0]} << lane_shift);
  end

  // Arbitration: D by default, I when alone or when D has starved it.
  // Gated by reset so nothing is granted while reset is held.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (reset && state == IDLE) begin
      if (i_req && (!d_req || starve_cnt == 4'(STARVE_LIMIT)))
        grant_i = 1'b1;
      else if (d_req)
        grant_d = 1'b1;
    end
  end

  // State, ownership, starvation counter and held result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      own_i      <= 1'b0;
      starve_cnt <= 4'd0;
      i_rdata_q  <= 32'd0;
      i_fault_q  <= 1'b0;
      d_rdata_q  <= 32'd0;
      d_fault_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_i)
        own_i <= 1'b1;
      else if (grant_d)
        own_i <= 1'b0;
      if (!i_req || grant_i)
        starve_cnt <= 4'd0;
      else if (grant_d)
        starve_cnt <= starve_cnt + 4'd1;
      if (i_ack) begin
        i_rdata_q <= i_rdata;
        i_fault_q <= i_fault;
      end
      if (d_ack) begin
        d_rdata_q <= d_rdata;
        d_fault_q <= d_fault;
      end
    end
  end

  // Next-state decision
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i)
          state_nxt = i_bad ? FAULT_ACK : RD_WAIT;
        else if (grant_d) begin
          if (d_bad)
            state_nxt = FAULT_ACK;
          else if (!d_write)
            state_nxt = RD_WAIT;
          else if (d_size == 2'd2)
            state_nxt = WR_DONE;
          else
            state_nxt = RMW_MERGE;
        end
      end
      RMW_MERGE: state_nxt = WR_DONE;
      RD_WAIT, WR_DONE, FAULT_ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes, acks and result outputs per state
  always_comb begin
    mem_enable  = 1'b0;
    mem_write   = 1'b0;
    mem_address = 32'd0;
    mem_wdata   = 32'd0;
    i_ack       = 1'b0;
    d_ack       = 1'b0;
    i_rdata     = i_rdata_q;
    i_fault     = i_fault_q;
    d_rdata     = d_rdata_q;
    d_fault     = d_fault_q;
    case (state)
      IDLE: begin
        if (grant_i && !i_bad) begin
          mem_enable  = 1'b1;
          mem_address = i_aligned;
        end else if (grant_d && !d_bad) begin
          mem_enable  = 1'b1;
          mem_address = d_aligned;
          if (d_write && d_size == 2'd2) begin
            mem_write = 1'b1;
            mem_wdata = d_wdata;
          end
        end
      end
      RD_WAIT: begin
        if (own_i) begin
          i_ack   = 1'b1;
          i_rdata = mem_rdata;
          i_fault = 1'b0;
        end else begin
          d_ack   = 1'b1;
          d_rdata = load_ext;
          d_fault = 1'b0;
        end
      end
      RMW_MERGE: begin
        mem_enable  = 1'b1;
        mem_write   = 1'b1;
        mem_address = d_aligned;
        mem_wdata   = merged;
      end
      WR_DONE: begin
        d_ack   = 1'b1;
        d_rdata = 32'd0;
        d_fault = 1'b0;
      end
      FAULT_ACK: begin
        if (own_i) begin
          i_ack   = 1'b1;
          i_rdata = 32'd0;
          i_fault = 1'b1;
        end else begin
          d_ack   = 1'b1;
          d_rdata = 32'd0;
          d_fault = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random accesses against a byte-array
// reference model of the memory contents and the access rules.
module tb_mem_arbiter;
  localparam int MEM_SIZE = 64000;
  localparam int STARVE   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack, i_fault;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_write, d_signed, d_ack, d_fault;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_enable, mem_write;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  logic [7:0] mem     [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.MEM_SIZE(MEM_SIZE), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_fault(i_fault),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_fault(d_fault),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read data
  always @(posedge clk) begin
    if (mem_enable && mem_address <= 32'(MEM_SIZE - 4)) begin
      mem_rdata <= {mem[mem_address+3], mem[mem_address+2], mem[mem_address+1], mem[mem_address]};
      if (mem_write)
        for (int k = 0; k < 4; k++) mem[mem_address+k] = mem_wdata[8*k +: 8];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Every memory access must be word aligned
  always @(negedge clk)
    if (mem_enable) check_val("mem_addr_align", {30'd0, mem_address[1:0]}, 32'd0);

  function automatic bit ref_fault_d(input logic [1:0] sz, input logic [31:0] a);
    longint base;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    base = longint'(a) - longint'(a % 4);
    return (base + 3) > (MEM_SIZE - 1);
  endfunction

  function automatic bit ref_fault_i(input logic [31:0] a);
    return ref_fault_d(2'd2, a);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn, input logic [31:0] a);
    int nb;
    logic [63:0] v;
    nb = 1 << sz;
    v = 0;
    for (int k = 0; k < nb; k++) v = v | (64'(ref_mem[a+k]) << (8*k));
    if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    w = wd;
    for (int k = 0; k < (1 << sz); k++) ref_mem[a+k] = 8'(w >> (8*k));
  endtask

  task automatic d_access(input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
    int cyc, en, wen, exp_lat, exp_en, exp_wen;
    bit got, flt;
    logic [31:0] exp_rd;
    flt     = ref_fault_d(sz, a);
    exp_rd  = (flt || wr) ? 32'd0 : ref_load(sz, sgn, a);
    exp_lat = (wr && !flt && sz != 2'd2) ? 3 : 2;
    exp_en  = flt ? 0 : ((wr && sz != 2'd2) ? 2 : 1);
    exp_wen = (flt || !wr) ? 0 : 1;
    @(posedge clk); #1;
    d_write = wr; d_size = sz; d_signed = sgn; d_addr = a; d_wdata = wd; d_req = 1'b1;
    cyc = 0; en = 0; wen = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_enable) en++;
      if (mem_enable && mem_write) wen++;
      if (d_ack) got = 1'b1;
    end
    check_val({tag, " ack"}, 32'(got), 32'd1);
    if (got) begin
      check_val({tag, " latency"}, cyc, exp_lat);
      check_val({tag, " fault"}, 32'(d_fault), 32'(flt));
      if (!wr || flt) check_val({tag, " rdata"}, d_rdata, exp_rd);
      check_val({tag, " mem_en_cycles"}, en, exp_en);
      check_val({tag, " mem_wr_cycles"}, wen, exp_wen);
      if (wr && !flt) ref_store(sz, a, wd);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    if (got && (!wr || flt)) check_val({tag, " rdata_hold"}, d_rdata, exp_rd);
  endtask

  task automatic i_fetch(input logic [31:0] a, input string tag);
    int cyc, en;
    bit got, flt;
    logic [31:0] exp_rd;
    flt    = ref_fault_i(a);
    exp_rd = flt ? 32'd0 : ref_load(2'd2, 1'b0, a);
    @(posedge clk); #1;
    i_addr = a; i_req = 1'b1;
    cyc = 0; en = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_enable) en++;
      if (i_ack) got = 1'b1;
    end
    check_val({tag, " ack"}, 32'(got), 32'd1);
    if (got) begin
      check_val({tag, " latency"}, cyc, 2);
      check_val({tag, " fault"}, 32'(i_fault), 32'(flt));
      check_val({tag, " rdata"}, i_rdata, exp_rd);
      check_val({tag, " mem_en_cycles"}, en, flt ? 0 : 1);
    end
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, ipos, cyc, nacc;
    bit got, i_done;
    logic [31:0] ra;
    logic [1:0] rsz;

    for (int i = 0; i < MEM_SIZE; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    // Reset held with both requesters active
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_write = 1'b0; d_size = 2'd2; d_signed = 1'b0; d_addr = 32'h10; d_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check_val("rst mem_enable", 32'(mem_enable), 32'd0);
    check_val("rst mem_write", 32'(mem_write), 32'd0);
    check_val("rst mem_address", mem_address, 32'd0);
    check_val("rst mem_wdata", mem_wdata, 32'd0);
    check_val("rst acks", {30'd0, i_ack, d_ack}, 32'd0);
    check_val("rst i_rdata", i_rdata, 32'd0);
    check_val("rst d_rdata", d_rdata, 32'd0);
    check_val("rst faults", {30'd0, i_fault, d_fault}, 32'd0);

    // Release: D is granted first
    #2 reset = 1'b1;
    #1;
    check_val("first grant mem_enable", 32'(mem_enable), 32'd1);
    check_val("first grant mem_write", 32'(mem_write), 32'd0);
    check_val("first grant mem_address", mem_address, 32'h10);
    @(negedge clk);
    check_val("first d_ack", 32'(d_ack), 32'd1);
    check_val("first i_ack", 32'(i_ack), 32'd0);
    check_val("first d_rdata", d_rdata, ref_load(2'd2, 1'b0, 32'h10));
    @(posedge clk); #1;
    d_req = 1'b0;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (i_ack) got = 1'b1;
    end
    check_val("pending fetch ack", 32'(got), 32'd1);
    check_val("pending fetch rdata", i_rdata, ref_load(2'd2, 1'b0, 32'h40));
    check_val("pending fetch fault", 32'(i_fault), 32'd0);
    @(posedge clk); #1;
    i_req = 1'b0;

    // Store / merge sequence
    d_access(1'b1, 2'd2, 1'b0, 32'h20, 32'hAABBCCDD, "st_word");
    d_access(1'b1, 2'd0, 1'b0, 32'h22, 32'h00000011, "st_byte");
    d_access(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, "ld_merged");
    check_val("merged word", d_rdata, 32'hAA11CCDD);

    // Subword load extension
    d_access(1'b1, 2'd2, 1'b0, 32'h20, 32'h80011234, "st_word2");
    d_access(1'b0, 2'd1, 1'b1, 32'h22, 32'd0, "ld_half_s");
    check_val("half signed", d_rdata, 32'hFFFF8001);
    d_access(1'b0, 2'd1, 1'b0, 32'h22, 32'd0, "ld_half_u");
    check_val("half unsigned", d_rdata, 32'h00008001);
    d_access(1'b0, 2'd0, 1'b1, 32'h23, 32'd0, "ld_byte_s");
    check_val("byte signed", d_rdata, 32'hFFFFFF80);
    d_access(1'b1, 2'd1, 1'b0, 32'h26, 32'h0000BEEF, "st_half");
    d_access(1'b0, 2'd2, 1'b0, 32'h24, 32'd0, "ld_after_half");

    // Faults and range boundaries
    d_access(1'b0, 2'd2, 1'b0, 32'h21, 32'd0, "flt_word_mis");
    check_val("fault rdata zero", d_rdata, 32'd0);
    d_access(1'b0, 2'd1, 1'b0, 32'h13, 32'd0, "flt_half_mis");
    d_access(1'b0, 2'd2, 1'b0, 32'(MEM_SIZE - 2), 32'd0, "flt_word_end");
    d_access(1'b0, 2'd3, 1'b0, 32'h24, 32'd0, "flt_size3");
    d_access(1'b1, 2'd2, 1'b0, 32'(MEM_SIZE), 32'h12345678, "flt_st_oor");
    d_access(1'b1, 2'd2, 1'b0, 32'(MEM_SIZE - 4), 32'hCAFEF00D, "st_last_word");
    d_access(1'b1, 2'd0, 1'b0, 32'(MEM_SIZE - 1), 32'h0000005A, "st_last_byte");
    d_access(1'b0, 2'd2, 1'b0, 32'(MEM_SIZE - 4), 32'd0, "ld_last_word");
    i_fetch(32'h44, "fetch_ok");
    i_fetch(32'h46, "fetch_mis");
    i_fetch(32'(MEM_SIZE), "fetch_oor");

    // Starvation: both held, D back-to-back
    @(posedge clk); #1;
    i_addr = 32'h48; i_req = 1'b1;
    d_write = 1'b0; d_size = 2'd2; d_signed = 1'b0; d_addr = 32'h0; d_req = 1'b1;
    nd = 0; ipos = -1; cyc = 0; nacc = 0; i_done = 1'b0;
    while (nacc < 7 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      got = 1'b0;
      if (d_ack) begin
        check_val("starve d_rdata", d_rdata, ref_load(2'd2, 1'b0, d_addr));
        nd++; nacc++; got = 1'b1;
      end
      if (i_ack) begin
        check_val("starve i_rdata", i_rdata, ref_load(2'd2, 1'b0, 32'h48));
        ipos = nd; nacc++; i_done = 1'b1;
      end
      @(posedge clk); #1;
      if (got) d_addr = 32'(nd * 4);
      if (i_done) i_req = 1'b0;
      if (nd >= 6) d_req = 1'b0;
    end
    check_val("starve i position", ipos, STARVE);
    check_val("starve d resumed", nd, 6);
    check_val("starve throughput cycles", cyc, 14);
    d_req = 1'b0; i_req = 1'b0;

    // Reset during the write-back half of a byte store
    @(posedge clk); #1;
    d_write = 1'b1; d_size = 2'd0; d_addr = 32'h31; d_wdata = 32'h000000EE; d_req = 1'b1;
    @(negedge clk);
    check_val("rmw read phase", {30'd0, mem_enable, mem_write}, 32'd2);
    @(negedge clk);
    check_val("rmw write phase", {30'd0, mem_enable, mem_write}, 32'd3);
    #1 reset = 1'b0;
    #1;
    check_val("rmw reset strobes", {30'd0, mem_enable, mem_write}, 32'd0);
    check_val("rmw reset no ack", 32'(d_ack), 32'd0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rmw reset still no ack", 32'(d_ack), 32'd0);
    #2 reset = 1'b1;
    check_val("rmw byte untouched", 32'(mem[32'h31]), 32'(ref_mem[32'h31]));
    d_access(1'b0, 2'd2, 1'b0, 32'h30, 32'd0, "ld_after_rmw_reset");

    // Random mix of fetches, loads and stores
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 7) == 0)
        ra = 32'(MEM_SIZE - 8) + 32'($urandom_range(0, 12));
      else
        ra = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 9) < 2) begin
        if ($urandom_range(0, 3) != 0) ra = {ra[31:2], 2'b00};
        i_fetch(ra, "rnd_fetch");
      end else begin
        rsz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        if ($urandom_range(0, 3) != 0) begin
          if (rsz == 2'd1) ra[0] = 1'b0;
          if (rsz == 2'd2) ra[1:0] = 2'b00;
        end
        d_access(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom, "rnd_d");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
